keypad_row_scan: RTL and testbench

KEYPAD_ROW_SCAN -- requirements
Module: keypad_row_scan

---
 rtl/keypad_row_scan.sv | 190 +++++++++++++++++++
 tb/tb_keypad_row_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_row_scan.sv
// Row-scanning keypad controller for a 4x4 matrix.
// Drives one row at a time and samples the synchronized column returns at the end of each row dwell.
// A key is accepted after DEBOUNCE_SCANS identical single-key sweeps, and key_valid pulses once per press.
module keypad_row_scan #(
    parameter int unsigned SCAN_TICKS     = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       error
);

    localparam int unsigned TICK_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    localparam logic [1:0] IDLE     = 2'b00;
    localparam logic [1:0] DEBOUNCE = 2'b01;
    localparam logic [1:0] HELD     = 2'b10;

    logic [3:0]        col_m;
    logic [3:0]        col_s;
    logic [TICK_W-1:0] tick;
    logic [3:0][3:0]   hit;

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [3:0]       cand_row;
    logic [3:0]       cand_row_d;
    logic [3:0]       cand_col;
    logic [3:0]       cand_col_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       key_row_d;
    logic [3:0]       key_col_d;
    logic             key_valid_d;
    logic             error_d;

    logic             sample_c;
    logic             sweep_end_c;
    logic [3:0][3:0]  pat_c;
    logic [2:0]       nz_rows_c;
    logic [3:0]       sgl_row_c;
    logic [3:0]       sgl_col_c;
    logic             none_c;
    logic             single_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Two-flop synchronizer for the asynchronous column returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m <= '0;
            col_s <= '0;
        end else begin
            col_m <= col_in;
            col_s <= col_m;
        end
    end

    assign sample_c    = (tick == TICK_LAST);
    assign sweep_end_c = sample_c && row_out[3];

    // Row dwell counter, row rotation and per-row hit capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= '0;
            row_out <= 4'b0001;
            hit     <= '0;
        end else if (sample_c) begin
            tick    <= '0;
            row_out <= {row_out[2:0], row_out[3]};
            for (int i = 0; i < 4; i++) begin
                if (row_out[i]) begin
                    hit[i] <= col_s;
                end
            end
        end else begin
            tick <= tick + TICK_W'(1);
        end
    end

    // Sweep classification; the last row's pattern is taken live from col_s at sweep end
    always_comb begin
        pat_c     = hit;
        nz_rows_c = '0;
        sgl_row_c = '0;
        sgl_col_c = '0;
        for (int i = 0; i < 4; i++) begin
            if (row_out[i]) begin
                pat_c[i] = col_s;
            end
            if (pat_c[i] != 4'b0000) begin
                nz_rows_c    = nz_rows_c + 3'd1;
                sgl_row_c[i] = 1'b1;
                sgl_col_c    = pat_c[i];
            end
        end
        none_c   = (nz_rows_c == 3'd0);
        single_c = (nz_rows_c == 3'd1) && $onehot(sgl_col_c);
    end

    assign cnt_inc_c = cnt + CNT_W'(1);

    // Debounce FSM: next state and next registered outputs
    always_comb begin
        state_d     = state;
        cand_row_d  = cand_row;
        cand_col_d  = cand_col;
        cnt_d       = cnt;
        key_row_d   = key_row;
        key_col_d   = key_col;
        key_valid_d = 1'b0;
        error_d     = error;
        if (sweep_end_c) begin
            error_d = !none_c && !single_c;
            case (state)
                IDLE: begin
                    if (single_c) begin
                        cand_row_d = sgl_row_c;
                        cand_col_d = sgl_col_c;
                        cnt_d      = CNT_W'(1);
                        if (DEB_TARGET == CNT_W'(1)) begin
                            state_d     = HELD;
                            key_row_d   = sgl_row_c;
                            key_col_d   = sgl_col_c;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!single_c) begin
                        state_d = IDLE;
                    end else if (sgl_row_c == cand_row && sgl_col_c == cand_col) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == DEB_TARGET) begin
                            state_d     = HELD;
                            key_row_d   = cand_row;
                            key_col_d   = cand_col;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        cand_row_d = sgl_row_c;
                        cand_col_d = sgl_col_c;
                        cnt_d      = CNT_W'(1);
                    end
                end
                HELD: begin
                    if (none_c) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand_row  <= '0;
            cand_col  <= '0;
            cnt       <= '0;
            key_row   <= '0;
            key_col   <= '0;
            key_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_d;
            cand_row  <= cand_row_d;
            cand_col  <= cand_col_d;
            cnt       <= cnt_d;
            key_row   <= key_row_d;
            key_col   <= key_col_d;
            key_valid <= key_valid_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_keypad_row_scan.sv
// Self-checking bench for keypad_row_scan with SCAN_TICKS=4, DEBOUNCE_SCANS=2 (16-clock sweeps).
module tb_keypad_row_scan;

    localparam int unsigned ST = 4;
    localparam int unsigned DS = 2;
    localparam int SW = 4 * ST;

    logic       clk;
    logic       rst_n;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_valid;
    logic       error;

    logic [3:0] pat [4];
    int cyc;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [3:0] row;
        logic [3:0] col;
    } exp_t;
    exp_t exp_q [$];

    keypad_row_scan #(
        .SCAN_TICKS    (ST),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_valid(key_valid),
        .error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad model: each row returns its configured column pattern while driven
    always_comb begin
        col_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (row_out[i]) col_in = col_in | pat[i];
        end
    end

    // Clocks since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard: every key_valid pulse must match the oldest expected acceptance
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && key_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL key_valid_unexpected: pulse at cycle %0d row=%b col=%b, none expected",
                             cyc, key_row, key_col);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc !== e.cyc || key_row !== e.row || key_col !== e.col) begin
                        n_bad++;
                        $display("FAIL key_valid_match: got cycle %0d row=%b col=%b, expected cycle %0d row=%b col=%b",
                                 cyc, key_row, key_col, e.cyc, e.row, e.col);
                    end
                end
            end
        end
    end

    task automatic clear_pat();
        for (int i = 0; i < 4; i++) pat[i] = 4'b0000;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_pat();
        repeat (3) @(negedge clk);
        n_cmp++; if (row_out !== 4'b0001) begin n_bad++; $display("FAIL reset_row_out: got %b expected 0001", row_out); end
        n_cmp++; if (key_row !== 4'b0000) begin n_bad++; $display("FAIL reset_key_row: got %b expected 0000", key_row); end
        n_cmp++; if (key_col !== 4'b0000) begin n_bad++; $display("FAIL reset_key_col: got %b expected 0000", key_col); end
        n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b expected 0", error); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [3:0] er;
        clear_pat();
        apply_reset();
        for (int n = 0; n < 4 * SW; n++) begin
            er = 4'(1 << ((n / ST) % 4));
            n_cmp++; if (row_out !== er) begin n_bad++; $display("FAIL idle_row_out: clk %0d got %b expected %b", n, row_out, er); end
            n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL idle_error: clk %0d got %b expected 0", n, error); end
            @(negedge clk);
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL idle_pending: %0d expected pulses not seen, expected 0", exp_q.size()); end
    endtask

    task automatic test_press();
        clear_pat();
        apply_reset();
        pat[1] = 4'b0100;
        exp_q.push_back('{cyc + 2 * SW, 4'b0010, 4'b0100});
        repeat (5 * SW) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL press_pending: %0d pulses missing, expected 0", exp_q.size()); end
        n_cmp++; if (key_row !== 4'b0010) begin n_bad++; $display("FAIL press_key_row: got %b expected 0010", key_row); end
        n_cmp++; if (key_col !== 4'b0100) begin n_bad++; $display("FAIL press_key_col: got %b expected 0100", key_col); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL press_error: got %b expected 0", error); end
    endtask

    task automatic test_repress();
        pat[1] = 4'b0000;
        repeat (SW) @(negedge clk);
        n_cmp++; if (key_row !== 4'b0010 || key_col !== 4'b0100) begin
            n_bad++; $display("FAIL release_hold: got row=%b col=%b expected row=0010 col=0100", key_row, key_col);
        end
        pat[1] = 4'b0100;
        exp_q.push_back('{cyc + 2 * SW, 4'b0010, 4'b0100});
        repeat (2 * SW) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL repress_pending: %0d pulses missing, expected 0", exp_q.size()); end
        n_cmp++; if (key_row !== 4'b0010 || key_col !== 4'b0100) begin
            n_bad++; $display("FAIL repress_key: got row=%b col=%b expected row=0010 col=0100", key_row, key_col);
        end
        pat[1] = 4'b0000;
        repeat (SW) @(negedge clk);
    endtask

    task automatic test_multi();
        pat[0] = 4'b0011;
        repeat (SW - 1) @(negedge clk);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL multi_early: got %b expected 0 before sweep end", error); end
        @(negedge clk);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL multi_col_error: got %b expected 1", error); end
        n_cmp++; if (key_row !== 4'b0010 || key_col !== 4'b0100) begin
            n_bad++; $display("FAIL multi_key_kept: got row=%b col=%b expected row=0010 col=0100", key_row, key_col);
        end
        pat[0] = 4'b0000;
        repeat (SW) @(negedge clk);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL multi_clear: got %b expected 0", error); end
        // single, multi-row, single, none: the multi sweep must abandon the candidate
        pat[0] = 4'b0001;
        repeat (SW) @(negedge clk);
        pat[2] = 4'b0001;
        repeat (SW) @(negedge clk);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL multi_row_error: got %b expected 1", error); end
        pat[2] = 4'b0000;
        repeat (SW) @(negedge clk);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL multi_single_error: got %b expected 0", error); end
        clear_pat();
        repeat (SW) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL multi_pending: %0d pulses missing, expected 0", exp_q.size()); end
        n_cmp++; if (key_row !== 4'b0010 || key_col !== 4'b0100) begin
            n_bad++; $display("FAIL multi_key_final: got row=%b col=%b expected row=0010 col=0100", key_row, key_col);
        end
    endtask

    task automatic test_back_to_back();
        pat[0] = 4'b0001;
        repeat (SW) @(negedge clk);
        pat[0] = 4'b0000;
        pat[3] = 4'b0010;
        exp_q.push_back('{cyc + 2 * SW, 4'b1000, 4'b0010});
        repeat (2 * SW) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_pending: %0d pulses missing, expected 0", exp_q.size()); end
        n_cmp++; if (key_row !== 4'b1000) begin n_bad++; $display("FAIL b2b_key_row: got %b expected 1000", key_row); end
        n_cmp++; if (key_col !== 4'b0010) begin n_bad++; $display("FAIL b2b_key_col: got %b expected 0010", key_col); end
        clear_pat();
        repeat (SW) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        pat[2] = 4'b1000;
        repeat (SW + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (row_out !== 4'b0001) begin n_bad++; $display("FAIL midrst_row_out: got %b expected 0001", row_out); end
        n_cmp++; if (key_row !== 4'b0000 || key_col !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_key: got row=%b col=%b expected 0000/0000", key_row, key_col);
        end
        n_cmp++; if (key_valid !== 1'b0 || error !== 1'b0) begin
            n_bad++; $display("FAIL midrst_flags: got valid=%b error=%b expected 0/0", key_valid, error);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{cyc + 2 * SW, 4'b0100, 4'b1000});
        repeat (SW) @(negedge clk);
        n_cmp++; if (key_row !== 4'b0000) begin n_bad++; $display("FAIL midrst_one_sweep: got row=%b expected 0000", key_row); end
        repeat (2 * SW) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL midrst_pending: %0d pulses missing, expected 0", exp_q.size()); end
        n_cmp++; if (key_row !== 4'b0100 || key_col !== 4'b1000) begin
            n_bad++; $display("FAIL midrst_key_final: got row=%b col=%b expected row=0100 col=1000", key_row, key_col);
        end
        clear_pat();
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press();
        test_repress();
        test_multi();
        test_back_to_back();
        test_reset_mid();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
